shift_left2: RTL and testbench

Parameterised left-shift-by-two unit for jump and branch target computation. It takes a W-bit field (typically the 26-bit jump index or a 32-bit sign-extended offset), shifts it left by SH bits and extends or truncates it to a 32-bit word address offset. The result is registered, giving a single pipeline stage that sits between instruction decode and the PC-target adder.

---
 rtl/shift_left2.sv | 82 ++++++++
 tb/tb_shift_left2.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_left2.sv
// -----------------------------------------------------------------------------
// shift_left2
//   Registered left-shift unit for jump/branch target computation. The W-bit
//   input field is zero- or sign-extended to OUT_W bits, shifted left by SH
//   (bits above OUT_W-1 are dropped, low SH bits are zero) and captured in a
//   single pipeline register that sits between decode and the PC-target adder.
//
// Parameters
//   W        : input field width (1..32)
//   OUT_W    : output width
//   SH       : left-shift amount (0..OUT_W-1)
//   SIGN_EXT : 0 = zero-extend, 1 = sign-extend from entrada[W-1]
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high; clears salida and valid immediately
//   en      : load enable; entrada is captured on the edge when high
//   entrada : field to shift (W bits)
//   salida  : registered shifted result (OUT_W bits)
//   valid   : high for each cycle whose salida came from an en-qualified edge
// -----------------------------------------------------------------------------
module shift_left2 #(
  parameter int W        = 26,
  parameter int OUT_W    = 32,
  parameter int SH       = 2,
  parameter int SIGN_EXT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [W-1:0]     entrada,
  output logic [OUT_W-1:0] salida,
  output logic             valid
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] shifted;
  logic [OUT_W-1:0] salida_d, salida_q;
  logic             valid_d,  valid_q;

  // Width adaptation. The W >= OUT_W branch avoids a zero-width replication
  // when the field already fills the output word.
  generate
    if (W >= OUT_W) begin : g_no_ext
      assign ext = entrada[OUT_W-1:0];
    end else if (SIGN_EXT != 0) begin : g_sign_ext
      assign ext = {{(OUT_W-W){entrada[W-1]}}, entrada};
    end else begin : g_zero_ext
      assign ext = {{(OUT_W-W){1'b0}}, entrada};
    end
  endgenerate

  // Shifting within OUT_W bits discards anything pushed past the MSB.
  assign shifted = ext << SH;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    salida_d = salida_q;
    valid_d  = 1'b0;
    if (en) begin
      salida_d = shifted;
      valid_d  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      salida_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      salida_q <= salida_d;
      valid_q  <= valid_d;
    end
  end

  assign salida = salida_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_shift_left2.sv
// -----------------------------------------------------------------------------
// tb_shift_left2
//   Drives four instances side by side (W=26 zero-ext, W=32, W=16 sign-ext,
//   W=16 zero-ext) from a shared clock/reset/en and compares them against an
//   arithmetic reference: result = (signed-or-unsigned value * 2**SH) mod 2**32.
// -----------------------------------------------------------------------------
module tb_shift_left2;

  localparam int N = 4;
  localparam int WS [N] = '{26, 32, 16, 16};
  localparam bit SX [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;
  logic [31:0] din [N];

  wire [31:0] sal0, sal1, sal2, sal3;
  wire        vld0, vld1, vld2, vld3;

  logic [31:0] exp_sal [N];
  logic        exp_val [N];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_left2 #(.W(26), .OUT_W(32), .SH(2), .SIGN_EXT(0)) u_w26 (
    .clk(clk), .reset(reset), .en(en), .entrada(din[0][25:0]),
    .salida(sal0), .valid(vld0));
  shift_left2 #(.W(32), .OUT_W(32), .SH(2), .SIGN_EXT(0)) u_w32 (
    .clk(clk), .reset(reset), .en(en), .entrada(din[1]),
    .salida(sal1), .valid(vld1));
  shift_left2 #(.W(16), .OUT_W(32), .SH(2), .SIGN_EXT(1)) u_w16s (
    .clk(clk), .reset(reset), .en(en), .entrada(din[2][15:0]),
    .salida(sal2), .valid(vld2));
  shift_left2 #(.W(16), .OUT_W(32), .SH(2), .SIGN_EXT(0)) u_w16z (
    .clk(clk), .reset(reset), .en(en), .entrada(din[3][15:0]),
    .salida(sal3), .valid(vld3));

  // Reference: interpret the low w bits as an unsigned or two's-complement
  // integer, multiply by 4, keep the result modulo 2**32.
  function automatic logic [31:0] ref_model(input logic [31:0] x, input int w,
                                            input bit sx);
    longint unsigned mask;
    longint          v;
    mask = (64'd1 << w) - 64'd1;
    v    = longint'({32'd0, x} & mask);
    if (sx && x[w-1]) v = v - (longint'(1) << w);
    v = v * 4;
    return v[31:0];
  endfunction

  function automatic logic [31:0] sal_of(input int i);
    case (i)
      0:       return sal0;
      1:       return sal1;
      2:       return sal2;
      default: return sal3;
    endcase
  endfunction

  function automatic logic vld_of(input int i);
    case (i)
      0:       return vld0;
      1:       return vld1;
      2:       return vld2;
      default: return vld3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_d%0d_salida", tag, i), sal_of(i), exp_sal[i]);
      check($sformatf("%s_d%0d_valid", tag, i), {31'd0, vld_of(i)},
            {31'd0, exp_val[i]});
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, update the model
  // with what that edge should have done, then sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] d3);
    @(negedge clk);
    reset  = r;
    en     = e;
    din[0] = d0;
    din[1] = d1;
    din[2] = d2;
    din[3] = d3;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        exp_sal[i] = '0;
        exp_val[i] = 1'b0;
      end else if (e) begin
        exp_sal[i] = ref_model(din[i], WS[i], SX[i]);
        exp_val[i] = 1'b1;
      end else begin
        exp_val[i] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      din[i]     = '0;
      exp_sal[i] = '0;
      exp_val[i] = 1'b0;
    end

    // Reset state
    #2;
    check_all("reset_init");
    step(1'b1, 1'b1, 32'h23, 32'h4F, 32'hFFFE, 32'hFFFE);
    check_all("reset_held");

    // First loads: spec values for each configuration
    step(1'b0, 1'b1, 32'h23, 32'h4F, 32'hFFFE, 32'hFFFE);
    check_all("load1");
    check("w26_23", sal0, 32'h0000008C);
    check("w32_4f", sal1, 32'h0000013C);
    check("w16_sext_fffe", sal2, 32'hFFFFFFF8);
    check("w16_zext_fffe", sal3, 32'h0003FFF8);

    step(1'b0, 1'b1, 32'h3FFFFFF, 32'h1, 32'h8000, 32'h7FFF);
    check_all("load2");
    check("w26_max", sal0, 32'h0FFFFFFC);
    check("w32_1", sal1, 32'h00000004);

    step(1'b0, 1'b1, 32'h0, 32'h80000001, 32'h1, 32'h8000);
    check_all("load3");
    check("w32_msb_lost", sal1, 32'h00000004);
    check("w32_valid_b2b", {31'd0, vld1}, 32'd1);

    // Hold with en low
    step(1'b0, 1'b1, 32'h23, 32'h4F, 32'h1234, 32'h1234);
    step(1'b0, 1'b0, 32'h3FFFFFF, 32'hFF, 32'hFFFF, 32'hFFFF);
    check_all("hold");
    check("hold_w32", sal1, 32'h0000013C);
    check("hold_valid", {31'd0, vld1}, 32'd0);

    // Reload, then asynchronous reset mid-cycle
    step(1'b0, 1'b1, 32'h23, 32'h4F, 32'h1, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_sal[i] = '0;
      exp_val[i] = 1'b0;
    end
    check_all("async_reset");
    check("async_reset_w32", sal1, 32'h0);

    // Reset/en collision: reset wins, then first edge after release loads
    step(1'b1, 1'b1, 32'h23, 32'h4F, 32'hFFFE, 32'hFFFE);
    check_all("collision");
    check("collision_w26", sal0, 32'h0);
    step(1'b0, 1'b1, 32'h23, 32'h4F, 32'hFFFE, 32'hFFFE);
    check_all("after_reset");
    check("after_reset_w26", sal0, 32'h0000008C);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, $urandom, $urandom);
      check_all($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
